// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
// Covers the fetched {pc, inst} entry, the request state and word alignment.
package pc_fetch_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic {
        REQ_IDLE,
        REQ_BUSY
    } req_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs.
// The head is read straight from storage and reads as zero when empty.
module pc_fetch_fifo
    import pc_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    assign head = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency memory and buffers returned instructions for IF/ID.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ack_i,
    input  logic [31:0] inst_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    req_state_t   state_reg;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  req_addr_reg;
    logic         discard_reg;

    logic         ack_seen;
    logic         push;
    logic         pop;
    logic         issue;
    logic [31:0]  issue_addr;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_after;
    fetch_entry_t push_data;
    fetch_entry_t head;

    // Acks arriving while nothing is outstanding are stray and ignored.
    assign ack_seen  = (state_reg == REQ_BUSY) && inst_ack_i;
    assign push      = ack_seen && !discard_reg && !branch_flag_i && (!fifo_full || pop);
    assign pop       = !fifo_empty && !stall_i && !branch_flag_i;
    assign push_data = '{pc: req_addr_reg, inst: inst_rdata_i};

    always_comb begin
        count_after = fifo_count;
        if (branch_flag_i) begin
            count_after = '0;
        end else if (push && !pop) begin
            count_after = fifo_count + 1'b1;
        end else if (!push && pop) begin
            count_after = fifo_count - 1'b1;
        end
    end

    // Credit check uses the occupancy after this cycle's push/pop, so a slot
    // freed by a pop can be refilled back-to-back.
    assign issue      = ((state_reg == REQ_IDLE) || ack_seen) && (count_after < DEPTH_CNT);
    assign issue_addr = branch_flag_i ? word_align(branch_target_i) : fetch_pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= REQ_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_addr_reg <= ZERO_WORD;
            discard_reg  <= 1'b0;
        end else begin
            if (issue) begin
                state_reg    <= REQ_BUSY;
                req_addr_reg <= issue_addr;
                fetch_pc_reg <= issue_addr + PC_STEP;
            end else begin
                if (ack_seen) begin
                    state_reg <= REQ_IDLE;
                end
                if (branch_flag_i) begin
                    fetch_pc_reg <= word_align(branch_target_i);
                end
            end
            // A redirect with a request still in flight must drop that request's data.
            if (ack_seen) begin
                discard_reg <= 1'b0;
            end else if (branch_flag_i && (state_reg == REQ_BUSY)) begin
                discard_reg <= 1'b1;
            end
        end
    end

    pc_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (branch_flag_i),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_req_o  = (state_reg == REQ_BUSY);
    assign inst_addr_o = req_addr_reg;
    assign if_valid_o  = !fifo_empty;
    assign if_pc_o     = head.pc;
    assign if_inst_o   = head.inst;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a memory model acks requests and checks
// their addresses, a monitor checks every instruction accepted by IF/ID.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    // Second instance exercising a non-zero reset PC near the wrap point.
    logic        b_stall;
    logic        b_branch;
    logic [31:0] b_target;
    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        b_valid;
    logic [31:0] b_pc;
    logic [31:0] b_inst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_out_q[$];

    int   acks_left;
    int   acks_done;
    int   mem_lat;
    logic stray_ack;

    pc_fetch u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_ack_i      (inst_ack_i),
        .inst_rdata_i    (inst_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    pc_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (b_stall),
        .branch_flag_i   (b_branch),
        .branch_target_i (b_target),
        .inst_req_o      (b_req),
        .inst_addr_o     (b_addr),
        .inst_ack_i      (b_ack),
        .inst_rdata_i    (b_rdata),
        .if_valid_o      (b_valid),
        .if_pc_o         (b_pc),
        .if_inst_o       (b_inst)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] addr, input bit keep);
        exp_addr_q.push_back(addr);
        if (keep) exp_out_q.push_back({addr, inst_of(addr)});
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_addr_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        n_checks++;
        if (exp_out_q.size() != 0 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d outputs and %0d requests pending, required 0",
                     name, exp_out_q.size(), exp_addr_q.size());
            exp_out_q.delete();
            exp_addr_q.delete();
        end else begin
            $display("ok   %s: drained after %0d cycles", name, n);
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr, input int bound);
        int n = 0;
        while (!(inst_req_o && inst_addr_o == addr) && n < bound) begin
            tick();
            n++;
        end
        check(name, inst_addr_o, addr);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        stall_i       = 1'b0;
        branch_flag_i = 1'b0;
        acks_left     = 0;
        mem_lat       = 0;
        stray_ack     = 1'b0;
        tick();
        tick();
        acks_done = 0;
        rst = 1'b1;
    endtask

    // Memory model: acks after mem_lat waiting cycles, only while acks are budgeted.
    initial begin
        int  mem_cnt;
        bit  real_ack;
        logic [31:0] want;
        mem_cnt      = 0;
        real_ack     = 1'b0;
        inst_ack_i   = 1'b0;
        inst_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (real_ack) mem_cnt = 0;
            real_ack = 1'b0;
            if (!rst) begin
                mem_cnt = 0;
            end else if (inst_req_o && acks_left > 0) begin
                if (mem_cnt >= mem_lat) begin
                    real_ack = 1'b1;
                    acks_left--;
                    acks_done++;
                    inst_rdata_i = inst_of(inst_addr_o);
                    n_checks++;
                    if (exp_addr_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL req_addr: got request %h, required no request", inst_addr_o);
                    end else begin
                        want = exp_addr_q.pop_front();
                        if (inst_addr_o !== want) begin
                            n_fail++;
                            $display("FAIL req_addr: got %h, required %h", inst_addr_o, want);
                        end else begin
                            $display("ok   req_addr: %h", inst_addr_o);
                        end
                    end
                end else begin
                    mem_cnt++;
                end
            end
            inst_ack_i = real_ack || stray_ack;
            if (stray_ack && !real_ack) inst_rdata_i = 32'hDEAD_BEEF;
        end
    end

    // Zero-latency memory for the wrap-around instance.
    initial begin
        b_ack   = 1'b0;
        b_rdata = 32'h0;
        forever begin
            @(negedge clk);
            b_ack   = b_req;
            b_rdata = inst_of(b_addr);
        end
    end

    // Monitor: every instruction accepted by IF/ID is checked against the scoreboard.
    initial begin
        logic [63:0] want;
        forever begin
            @(negedge clk);
            if (rst && if_valid_o && !stall_i && !branch_flag_i) begin
                n_checks++;
                if (exp_out_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL if_out: got pc %h inst %h, required no output", if_pc_o, if_inst_o);
                end else begin
                    want = exp_out_q.pop_front();
                    if ({if_pc_o, if_inst_o} !== want) begin
                        n_fail++;
                        $display("FAIL if_out: got pc %h inst %h, required pc %h inst %h",
                                 if_pc_o, if_inst_o, want[63:32], want[31:0]);
                    end else begin
                        $display("ok   if_out: pc %h inst %h", if_pc_o, if_inst_o);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] t1_addrs [4];
        logic [31:0] t2_addrs [6];
        t1_addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
        t2_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};

        rst             = 1'b0;
        stall_i         = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        stray_ack       = 1'b0;
        acks_left       = 0;
        acks_done       = 0;
        mem_lat         = 0;
        b_stall         = 1'b0;
        b_branch        = 1'b0;
        b_target        = 32'h0;
        tick();
        tick();

        check("rst_req",   32'(inst_req_o), 32'd0);
        check("rst_addr",  inst_addr_o,     32'h0);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_pc",    if_pc_o,         32'h0);
        check("rst_inst",  if_inst_o,       32'h0);

        // 1: one-cycle memory latency, sequential stream
        do_reset();
        mem_lat = 1;
        foreach (t1_addrs[i]) expect_fetch(t1_addrs[i], 1'b1);
        acks_left = 4;
        wait_drain("t1_drain", 60);
        check("t1_next_req",  32'(inst_req_o), 32'd1);
        check("t1_next_addr", inst_addr_o,     32'h10);

        // 2: stall with zero-latency memory fills exactly the buffer
        do_reset();
        stall_i = 1'b1;
        mem_lat = 0;
        foreach (t2_addrs[i]) expect_fetch(t2_addrs[i], 1'b1);
        acks_left = 6;
        repeat (12) tick();
        check("t2_acks_buffered", 32'(acks_done), 32'd2);
        check("t2_req_idle",      32'(inst_req_o), 32'd0);
        check("t2_valid",         32'(if_valid_o), 32'd1);
        check("t2_head_pc",       if_pc_o,         32'h0);
        stall_i = 1'b0;
        wait_drain("t2_drain", 60);

        // 3: redirect while 0x10 is outstanding, ack three cycles later
        do_reset();
        mem_lat = 0;
        foreach (t1_addrs[i]) expect_fetch(t1_addrs[i], 1'b1);
        acks_left = 4;
        wait_drain("t3_prefix", 60);
        wait_req("t3_pending_addr", 32'h10, 10);
        expect_fetch(32'h10, 1'b0);
        expect_fetch(32'h100, 1'b1);
        expect_fetch(32'h104, 1'b1);
        mem_lat         = 3;
        acks_left       = 3;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0103;
        tick();
        branch_flag_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_flushed_valid", 32'(if_valid_o), 32'd0);
            check("t3_hold_addr",     inst_addr_o,     32'h10);
            tick();
        end
        check("t3_target_req",  32'(inst_req_o), 32'd1);
        check("t3_target_addr", inst_addr_o,     32'h100);
        wait_drain("t3_drain", 60);

        // 4: redirect in the same cycle as the ack of 0x20
        do_reset();
        mem_lat = 2;
        for (int i = 0; i < 8; i++) expect_fetch(32'(i * 4), 1'b1);
        acks_left = 8;
        wait_drain("t4_prefix", 100);
        wait_req("t4_pending_addr", 32'h20, 10);
        expect_fetch(32'h20, 1'b0);
        expect_fetch(32'h200, 1'b1);
        expect_fetch(32'h204, 1'b1);
        mem_lat         = 0;
        acks_left       = 3;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0202;
        tick();
        branch_flag_i = 1'b0;
        check("t4_dropped_valid", 32'(if_valid_o), 32'd0);
        check("t4_target_req",    32'(inst_req_o), 32'd1);
        check("t4_target_addr",   inst_addr_o,     32'h200);
        wait_drain("t4_drain", 60);

        // 5: PC wraps from FFFF_FFFC to 0 on the second instance
        do_reset();
        tick();
        check("t5_req",      32'(b_req), 32'd1);
        check("t5_addr0",    b_addr,     32'hFFFF_FFF8);
        tick();
        check("t5_addr1",    b_addr,     32'hFFFF_FFFC);
        check("t5_valid",    32'(b_valid), 32'd1);
        check("t5_pc0",      b_pc,       32'hFFFF_FFF8);
        check("t5_inst0",    b_inst,     inst_of(32'hFFFF_FFF8));
        tick();
        check("t5_addr2",    b_addr,     32'h0000_0000);
        check("t5_pc1",      b_pc,       32'hFFFF_FFFC);
        tick();
        check("t5_addr3",    b_addr,     32'h0000_0004);
        check("t5_pc2",      b_pc,       32'h0000_0000);

        // 6: reset asserted mid-request, stray ack afterwards
        do_reset();
        stall_i = 1'b1;
        mem_lat = 0;
        expect_fetch(32'h0, 1'b0);
        acks_left = 1;
        repeat (4) tick();
        check("t6_busy_req",  32'(inst_req_o), 32'd1);
        check("t6_busy_addr", inst_addr_o,     32'h4);
        check("t6_busy_valid", 32'(if_valid_o), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_req",   32'(inst_req_o), 32'd0);
        check("t6_rst_addr",  inst_addr_o,     32'h0);
        check("t6_rst_valid", 32'(if_valid_o), 32'd0);
        check("t6_rst_pc",    if_pc_o,         32'h0);
        check("t6_rst_inst",  if_inst_o,       32'h0);
        stray_ack = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_restart_req",   32'(inst_req_o), 32'd1);
        check("t6_restart_addr",  inst_addr_o,     32'h0);
        check("t6_stray_ignored", 32'(if_valid_o), 32'd0);
        stray_ack = 1'b0;
        stall_i   = 1'b0;
        expect_fetch(32'h0, 1'b1);
        acks_left = 1;
        wait_drain("t6_drain", 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
